rr_burst_arbiter: RTL and testbench

Round-robin arbiter with burst hold that shares one registered valid/ready output stage among N upstream requesters. Each beat carries DW data bits. The block selects one valid requester per accepted beat and stores its data and source index in the output register. A source may keep the grant for up to BURST consecutive beats; then the grant rotates. It sits in front of a single downstream consumer, such as the valid-beat slave stage, wherever several producers contend for that consumer.

---
 rtl/rr_burst_arbiter.sv | 93 +++++++++
 tb/tb_rr_burst_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst hold: N valid/ready requesters share one
// registered valid/ready output stage; a winner may keep the grant for BURST beats.
module rr_burst_arbiter #(
  parameter  int N     = 4,
  parameter  int DW    = 3,
  parameter  int BURST = 2,
  localparam int SW    = $clog2(N),
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [SW-1:0]   out_src,
  input  logic            out_ready
);

  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  logic            out_valid_q;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]   out_src_q;
  logic [SW-1:0]   last_src_q, winner;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [SW-1:0]   cand;
  logic            found;
  logic            hold;
  logic            any_valid;
  logic            can_take;
  logic            accept;

  assign any_valid = |req_valid;
  assign can_take  = out_ready || !out_valid_q;
  assign accept    = can_take && any_valid;
  assign hold      = (burst_cnt_q != '0) && (burst_cnt_q < BURST_C) && req_valid[last_src_q];

  // Scan starts just after last_src and ends on last_src itself.
  always_comb begin
    winner = last_src_q;
    found  = 1'b0;
    cand   = '0;
    if (!hold) begin
      for (int i = 1; i <= N; i++) begin
        cand = SW'((int'(last_src_q) + i) % N);
        if (!found && req_valid[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    out_data_d = req_data[int'(winner)*DW +: DW];
    if (winner != last_src_q)
      burst_cnt_d = CW'(1);
    else if (burst_cnt_q >= BURST_C)
      burst_cnt_d = BURST_C;
    else
      burst_cnt_d = burst_cnt_q + CW'(1);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      last_src_q  <= SW'(N - 1);
      burst_cnt_q <= '0;
    end else begin
      if (can_take) out_valid_q <= any_valid;
      if (accept) begin
        out_data_q  <= out_data_d;
        out_src_q   <= winner;
        last_src_q  <= winner;
        burst_cnt_q <= burst_cnt_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: burst rotation, pure round-robin,
// backpressure, burst hold across idle, wrap-around and mid-stream reset.
module tb_rr_burst_arbiter;

  logic        sys_clk;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [11:0] req_data;
  logic        out_valid, out_ready;
  logic [2:0]  out_data;
  logic [1:0]  out_src;

  logic [3:0]  rv1, rr1;
  logic [11:0] rd1;
  logic        ov1, or1;
  logic [2:0]  od1;
  logic [1:0]  os1;

  int passed = 0;
  int total  = 0;

  rr_burst_arbiter #(.N(4), .DW(3), .BURST(2)) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  rr_burst_arbiter #(.N(4), .DW(3), .BURST(1)) u_rr (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
    .out_valid(ov1), .out_data(od1), .out_src(os1),
    .out_ready(or1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  int src_tab[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int rr_tab[4]  = '{1, 3, 1, 3};

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    req_data  = {3'd4, 3'd3, 3'd2, 3'd1};
    rv1       = 4'b0000;
    or1       = 1'b1;
    rd1       = {3'd4, 3'd3, 3'd2, 3'd1};
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Full stream, BURST=2: each source wins two beats in turn.
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("burst_ready%0d", k), 32'(req_ready), 32'(1 << src_tab[k]));
      tick();
      chk($sformatf("burst_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("burst_src%0d", k), 32'(out_src), 32'(src_tab[k]));
      chk($sformatf("burst_data%0d", k), 32'(out_data), 32'(src_tab[k] + 1));
    end

    // Backpressure on a stream from source 2.
    req_valid = 4'b0100;
    #1;
    chk("bp_ready_pre", 32'(req_ready), 32'b0100);
    tick();
    chk("bp_src_first", 32'(out_src), 32'd2);
    chk("bp_data_first", 32'(out_data), 32'd3);
    out_ready = 1'b0;
    req_data  = {3'd4, 3'd5, 3'd2, 3'd1};
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_src%0d", k), 32'(out_src), 32'd2);
      chk($sformatf("bp_data%0d", k), 32'(out_data), 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("bp_release_data", 32'(out_data), 32'd5);
    chk("bp_release_src", 32'(out_src), 32'd2);

    // Source 0 once, idle gap, then 0 keeps its burst before 1 gets a turn.
    req_valid = 4'b0001;
    req_data  = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    chk("brk_src0", 32'(out_src), 32'd0);
    req_valid = 4'b0000;
    tick();
    chk("brk_idle_valid", 32'(out_valid), 32'd0);
    tick();
    req_valid = 4'b0011;
    #1;
    chk("brk_hold_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("brk_hold_src", 32'(out_src), 32'd0);
    chk("brk_hold_data", 32'(out_data), 32'd1);
    chk("brk_next_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("brk_next_src", 32'(out_src), 32'd1);
    chk("brk_next_data", 32'(out_data), 32'd2);

    // Source 3 exhausts its burst, then the scan wraps to 0.
    req_valid = 4'b1000;
    tick();
    chk("wrap_s3a", 32'(out_src), 32'd3);
    tick();
    chk("wrap_s3b", 32'(out_src), 32'd3);
    req_valid = 4'b1001;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("wrap_src", 32'(out_src), 32'd0);
    chk("wrap_data", 32'(out_data), 32'd1);

    // Asynchronous reset with a beat pending at the output.
    chk("mrst_pre_valid", 32'(out_valid), 32'd1);
    req_valid = 4'b0110;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_src", 32'(out_src), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mrst_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("mrst_first_src", 32'(out_src), 32'd1);
    chk("mrst_first_data", 32'(out_data), 32'd2);
    req_valid = 4'b0000;

    // Pure round-robin instance: 1 and 3 alternate.
    rv1 = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_ready%0d", k), 32'(rr1), 32'(1 << rr_tab[k]));
      tick();
      chk($sformatf("rr_valid%0d", k), 32'(ov1), 32'd1);
      chk($sformatf("rr_src%0d", k), 32'(os1), 32'(rr_tab[k]));
      chk($sformatf("rr_data%0d", k), 32'(od1), 32'(rr_tab[k] + 1));
    end
    rv1 = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
